// File: rtl/uart_frame_packetizer.sv
// Drains an FWFT byte FIFO into framed UART packets: SOF, LEN, payload, optional checksum.
// One byte in flight at a time; each send state holds while tx_ready is low (payload also waits on FIFO data).
module uart_frame_packetizer #(
    parameter int          MAX_PAYLOAD = 8,
    parameter int          TIMEOUT     = 64,
    parameter logic [7:0]  SOF_BYTE    = 8'hA5,
    parameter int          CHK_MODE    = 1,
    parameter int          LVL_W       = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [LVL_W-1:0] fifo_level,
    input  logic [7:0]       fifo_data_out,
    output logic             fifo_rd_en,
    output logic             uart_start_tx,
    output logic [7:0]       uart_data_to_tx,
    input  logic             uart_tx_done,
    input  logic             tx_ready,
    output logic             tx_busy,
    output logic             pkt_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GATHER,
        S_SEND_SOF,
        S_SEND_LEN,
        S_SEND_PAY,
        S_SEND_CHK,
        S_WAIT_DONE
    } state_t;

    typedef enum logic [1:0] {
        RET_SOF,
        RET_LEN,
        RET_PAY,
        RET_CHK
    } ret_t;

    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [7:0]       MAX_LEN  = 8'(MAX_PAYLOAD);
    localparam logic [LVL_W-1:0] MAX_LVL  = LVL_W'(MAX_PAYLOAD);

    state_t           state_q;
    ret_t             ret_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       len_q;
    logic [7:0]       pay_cnt_q;
    logic [7:0]       chk_q;
    logic [7:0]       data_q;
    logic             start_q;
    logic             rd_en_q;
    logic             busy_q;
    logic             pkt_done_q;

    logic             level_full;
    logic             gather_exit;
    logic [7:0]       len_d;
    logic [7:0]       chk_byte;
    logic [7:0]       chk_d;

    // A full FIFO wins over the timeout, so a simultaneous exit still latches MAX_PAYLOAD.
    always_comb begin
        level_full  = (fifo_level >= MAX_LVL);
        gather_exit = level_full || (cnt_q == TMO_LAST);
        len_d       = level_full ? MAX_LEN : 8'(fifo_level);
        chk_byte    = (state_q == S_SEND_PAY) ? fifo_data_out : len_q;
        chk_d       = (CHK_MODE == 2) ? (chk_q ^ chk_byte) : (chk_q + chk_byte);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ret_q      <= RET_SOF;
            cnt_q      <= '0;
            len_q      <= 8'h00;
            pay_cnt_q  <= 8'h00;
            chk_q      <= 8'h00;
            data_q     <= 8'h00;
            start_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            pkt_done_q <= 1'b0;
        end else begin
            start_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            pkt_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        state_q <= S_GATHER;
                        cnt_q   <= '0;
                    end
                end
                S_GATHER: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (gather_exit) begin
                        state_q   <= S_SEND_SOF;
                        len_q     <= len_d;
                        chk_q     <= 8'h00;
                        pay_cnt_q <= 8'h00;
                        busy_q    <= 1'b1;
                    end
                end
                S_SEND_SOF: begin
                    if (tx_ready) begin
                        data_q  <= SOF_BYTE;
                        start_q <= 1'b1;
                        ret_q   <= RET_SOF;
                        state_q <= S_WAIT_DONE;
                    end
                end
                S_SEND_LEN: begin
                    if (tx_ready) begin
                        data_q  <= len_q;
                        chk_q   <= chk_d;
                        start_q <= 1'b1;
                        ret_q   <= RET_LEN;
                        state_q <= S_WAIT_DONE;
                    end
                end
                S_SEND_PAY: begin
                    if (tx_ready && !fifo_empty) begin
                        data_q    <= fifo_data_out;
                        chk_q     <= chk_d;
                        rd_en_q   <= 1'b1;
                        start_q   <= 1'b1;
                        pay_cnt_q <= pay_cnt_q + 8'd1;
                        ret_q     <= RET_PAY;
                        state_q   <= S_WAIT_DONE;
                    end
                end
                S_SEND_CHK: begin
                    if (tx_ready) begin
                        data_q  <= chk_q;
                        start_q <= 1'b1;
                        ret_q   <= RET_CHK;
                        state_q <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (uart_tx_done) begin
                        case (ret_q)
                            RET_SOF: state_q <= S_SEND_LEN;
                            RET_LEN: state_q <= S_SEND_PAY;
                            RET_PAY: begin
                                if (pay_cnt_q < len_q) begin
                                    state_q <= S_SEND_PAY;
                                end else if (CHK_MODE == 0) begin
                                    state_q    <= S_IDLE;
                                    busy_q     <= 1'b0;
                                    pkt_done_q <= 1'b1;
                                end else begin
                                    state_q <= S_SEND_CHK;
                                end
                            end
                            RET_CHK: begin
                                state_q    <= S_IDLE;
                                busy_q     <= 1'b0;
                                pkt_done_q <= 1'b1;
                            end
                        endcase
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign fifo_rd_en      = rd_en_q;
    assign uart_start_tx   = start_q;
    assign uart_data_to_tx = data_q;
    assign tx_busy         = busy_q;
    assign pkt_done        = pkt_done_q;

endmodule
